// File: rtl/div_sched_if.sv
// Client-side request/response bundle for div_sched: two requesters,
// each with an operand channel and a result channel.
interface div_sched_if #(
  parameter int K = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*(K+32)-1:0] req_x;
  logic [2*K-1:0]      req_d;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [2*K-1:0]      rsp_q;
  logic [2*K-1:0]      rsp_r;
  logic [1:0]          rsp_ovf;

  modport master (
    output req_valid, req_x, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_ovf
  );

  modport slave (
    input  req_valid, req_x, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_q, rsp_r, rsp_ovf
  );
endinterface

// File: rtl/div_sched.sv
// div_sched: shares one fixed-latency, non-stallable pipelined divider
// between two requesters. Round-robin issue, tag tracking through a
// LAT-deep shift register, and per-requester result FIFOs. A requester
// may only issue while its credit (FIFO occupancy + in-flight ops) is
// below DEPTH, so every result leaving the divider has a slot waiting.
module div_sched #(
  parameter int K     = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rstn,
  div_sched_if.slave    bus,
  output logic [K+31:0] div_x,
  output logic [K-1:0]  div_d,
  input  logic [K-1:0]  div_q,
  input  logic [K-1:0]  div_r
);
  localparam int XW = K + 32;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Which requester was granted most recently; reset value lets 0 win first.
  typedef enum logic {LAST0, LAST1} last_t;

  last_t         last_q;
  logic [CW-1:0] cnt [2];
  logic [1:0]    cand;
  logic [1:0]    grant;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          govf;

  // In-flight tag pipeline: {valid, id, ovf} per stage
  logic sr_v   [LAT];
  logic sr_id  [LAT];
  logic sr_ovf [LAT];

  // Result FIFOs
  logic [K-1:0]  mq  [2][DEPTH];
  logic [K-1:0]  mr  [2][DEPTH];
  logic          mo  [2][DEPTH];
  logic [AW-1:0] wp  [2];
  logic [AW-1:0] rp  [2];
  logic [CW-1:0] occ [2];

  // Eligibility and round-robin grant; nothing is granted while in reset
  always_comb begin
    cand  = '0;
    grant = '0;
    for (int unsigned i = 0; i < 2; i++)
      cand[i] = bus.req_valid[i] && (cnt[i] < CW'(DEPTH));
    if (!rstn)
      grant = '0;
    else if (cand == 2'b11)
      grant = (last_q == LAST1) ? 2'b01 : 2'b10;
    else
      grant = cand;
  end

  assign bus.req_ready = grant;

  // Drive divider operands from the granted requester, zero when idle
  always_comb begin
    div_x = '0;
    div_d = '0;
    if (grant[0]) begin
      div_x = bus.req_x[0 +: XW];
      div_d = bus.req_d[0 +: K];
    end else if (grant[1]) begin
      div_x = bus.req_x[XW +: XW];
      div_d = bus.req_d[K +: K];
    end
    // Quotient overflows K bits exactly when the upper dividend half >= d
    govf = (div_x[XW-1:32] >= div_d);
  end

  // Last-grant pointer moves only when something is granted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      last_q <= LAST1;
    else if (grant[0])
      last_q <= LAST0;
    else if (grant[1])
      last_q <= LAST1;
  end

  // Tag shift register, advanced every cycle alongside the divider pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned j = 0; j < unsigned'(LAT); j++) begin
        sr_v[j]   <= 1'b0;
        sr_id[j]  <= 1'b0;
        sr_ovf[j] <= 1'b0;
      end
    end else begin
      sr_v[0]   <= |grant;
      sr_id[0]  <= grant[1];
      sr_ovf[0] <= govf;
      for (int unsigned j = 1; j < unsigned'(LAT); j++) begin
        sr_v[j]   <= sr_v[j-1];
        sr_id[j]  <= sr_id[j-1];
        sr_ovf[j] <= sr_ovf[j-1];
      end
    end
  end

  // Writeback steering and consumer pops
  always_comb begin
    push    = '0;
    pop     = '0;
    push[0] = sr_v[LAT-1] && !sr_id[LAT-1];
    push[1] = sr_v[LAT-1] &&  sr_id[LAT-1];
    pop     = bus.rsp_valid & bus.rsp_ready;
  end

  // Credit counters: +1 on grant, -1 on pop, both cancel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 2; i++)
        cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i] && !pop[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (!grant[i] && pop[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        occ[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i])
          wp[i] <= (wp[i] == AW'(DEPTH - 1)) ? '0 : wp[i] + AW'(1);
        if (pop[i])
          rp[i] <= (rp[i] == AW'(DEPTH - 1)) ? '0 : rp[i] + AW'(1);
        if (push[i] && !pop[i])
          occ[i] <= occ[i] + CW'(1);
        else if (!push[i] && pop[i])
          occ[i] <= occ[i] - CW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while empty, outputs are gated
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        mq[i][wp[i]] <= div_q;
        mr[i][wp[i]] <= div_r;
        mo[i][wp[i]] <= sr_ovf[LAT-1];
      end
    end
  end

  // Head-of-FIFO presentation, forced to zero when empty
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_q     = '0;
    bus.rsp_r     = '0;
    bus.rsp_ovf   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (occ[i] != '0) begin
        bus.rsp_valid[i]     = 1'b1;
        bus.rsp_q[i*K +: K]  = mq[i][rp[i]];
        bus.rsp_r[i*K +: K]  = mr[i][rp[i]];
        bus.rsp_ovf[i]       = mo[i][rp[i]];
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: models the external pipelined divider, and keeps a
// transaction-level reference (per-requester queues of accepted operands
// with their due cycle, outstanding-op counts, last-grant flag).
module tb_div_sched;
  localparam int K     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
  localparam int XW    = K + 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [XW-1:0] div_x;
  logic [K-1:0]  div_d;
  logic [K-1:0]  div_q;
  logic [K-1:0]  div_r;

  div_sched_if #(.K(K)) bus ();

  div_sched #(.K(K), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .div_x (div_x),
    .div_d (div_d),
    .div_q (div_q),
    .div_r (div_r)
  );

  always #5 clk = ~clk;

  // Divider model: LAT register stages, d==0 yields arbitrary values
  logic [K-1:0] pq [LAT];
  logic [K-1:0] pr [LAT];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < LAT; j++) begin
        pq[j] <= '0;
        pr[j] <= '0;
      end
    end else begin
      if (div_d != '0) begin
        pq[0] <= K'(div_x / {32'b0, div_d});
        pr[0] <= K'(div_x % {32'b0, div_d});
      end else begin
        pq[0] <= '1;
        pr[0] <= div_x[K-1:0];
      end
      for (int j = 1; j < LAT; j++) begin
        pq[j] <= pq[j-1];
        pr[j] <= pr[j-1];
      end
    end
  end
  assign div_q = pq[LAT-1];
  assign div_r = pr[LAT-1];

  typedef struct {
    logic [XW-1:0] x;
    logic [K-1:0]  d;
    int            due;
  } op_t;

  op_t  fq [2][$];
  int   outst [2];
  logic mlast;
  int   cyc;
  int   checks;
  int   errors;

  // Stimulus staged by the test and applied shortly after the clock edge
  logic          s_rstn;
  logic [1:0]    s_valid;
  logic [1:0]    s_rr;
  logic [XW-1:0] s_x [2];
  logic [K-1:0]  s_d [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [1:0]    cand;
    logic [1:0]    g;
    logic [1:0]    pv;
    logic [1:0]    acc;
    logic [1:0]    pops;
    logic [XW-1:0] ex;
    logic [K-1:0]  ed;
    logic          eovf;
    op_t           op;
    @(posedge clk);
    cyc++;
    #1;
    rstn          = s_rstn;
    bus.req_valid = s_valid;
    bus.rsp_ready = s_rr;
    bus.req_x     = {s_x[1], s_x[0]};
    bus.req_d     = {s_d[1], s_d[0]};
    #3;
    if (!rstn) begin
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("rst_rsp_q", bus.rsp_q, 64'd0);
      chk("rst_rsp_r", bus.rsp_r, 64'd0);
      chk("rst_rsp_ovf", bus.rsp_ovf, 2'b00);
      chk("rst_div_x", div_x, 64'd0);
      chk("rst_div_d", div_d, 64'd0);
      fq[0].delete();
      fq[1].delete();
      outst[0] = 0;
      outst[1] = 0;
      mlast    = 1'b1;
      return;
    end
    for (int i = 0; i < 2; i++)
      cand[i] = s_valid[i] && (outst[i] < DEPTH);
    if (cand == 2'b11)
      g = mlast ? 2'b01 : 2'b10;
    else
      g = cand;
    chk("req_ready", bus.req_ready, g);
    ex = g[0] ? s_x[0] : (g[1] ? s_x[1] : '0);
    ed = g[0] ? s_d[0] : (g[1] ? s_d[1] : '0);
    chk("div_x", div_x, ex);
    chk("div_d", div_d, ed);
    for (int i = 0; i < 2; i++)
      pv[i] = (fq[i].size() != 0) && (fq[i][0].due <= cyc);
    chk("rsp_valid", bus.rsp_valid, pv);
    acc  = bus.req_valid & bus.req_ready;
    pops = bus.rsp_valid & bus.rsp_ready;
    for (int i = 0; i < 2; i++) begin
      if (pops[i]) begin
        chk("pop_has_entry", fq[i].size() != 0, 1'b1);
        if (fq[i].size() != 0) begin
          op   = fq[i].pop_front();
          eovf = ((op.x >> 32) >= {32'b0, op.d});
          chk("rsp_ovf", bus.rsp_ovf[i], eovf);
          if (!eovf) begin
            chk("rsp_q", bus.rsp_q[i*K +: K], op.x / {32'b0, op.d});
            chk("rsp_r", bus.rsp_r[i*K +: K], op.x % {32'b0, op.d});
          end
          outst[i]--;
        end
      end
      if (acc[i]) begin
        op.x   = s_x[i];
        op.d   = s_d[i];
        op.due = cyc + LAT + 1;
        fq[i].push_back(op);
        outst[i]++;
        chk("credit_bound", outst[i] <= DEPTH, 1'b1);
      end
    end
    if (g == 2'b01)
      mlast = 1'b0;
    else if (g == 2'b10)
      mlast = 1'b1;
  endtask

  task automatic rand_op(input int i);
    logic [31:0] hi;
    logic [K-1:0] d;
    if ($urandom_range(0, 15) == 0)
      d = '0;
    else if ($urandom_range(0, 3) == 0)
      d = K'($urandom_range(1, 255));
    else
      d = $urandom;
    if (d != '0 && $urandom_range(0, 7) != 0)
      hi = $urandom % d;
    else
      hi = $urandom;
    s_x[i] = {hi, 32'($urandom)};
    s_d[i] = d;
  endtask

  initial begin
    int n0;
    int n1;
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    mlast    = 1'b1;
    outst[0] = 0;
    outst[1] = 0;
    s_rstn   = 1'b0;
    s_valid  = '0;
    s_rr     = '0;
    s_x[0]   = '0;
    s_x[1]   = '0;
    s_d[0]   = '0;
    s_d[1]   = '0;

    repeat (2) tick();
    s_rstn = 1'b1;
    s_rr   = 2'b11;
    tick();

    // Single op: 100/7
    s_valid = 2'b01;
    s_x[0]  = 64'd100;
    s_d[0]  = 32'd7;
    tick();
    chk("single_accept", bus.req_ready[0], 1'b1);
    s_valid = 2'b00;
    tick();
    chk("single_lat1", bus.rsp_valid[0], 1'b0);
    tick();
    chk("single_lat2", bus.rsp_valid[0], 1'b0);
    tick();
    chk("single_valid", bus.rsp_valid[0], 1'b1);
    chk("single_q", bus.rsp_q[K-1:0], 64'd14);
    chk("single_r", bus.rsp_r[K-1:0], 64'd2);
    chk("single_ovf", bus.rsp_ovf[0], 1'b0);
    repeat (2) tick();

    // Overflow and divide-by-zero
    s_valid = 2'b01;
    s_x[0]  = 64'h5_0000_0000;
    s_d[0]  = 32'd3;
    tick();
    s_x[0]  = 64'd9;
    s_d[0]  = 32'd0;
    tick();
    s_valid = 2'b00;
    tick();
    tick();
    chk("ovf_big", bus.rsp_ovf[0], 1'b1);
    tick();
    chk("ovf_zero", bus.rsp_ovf[0], 1'b1);
    s_valid = 2'b01;
    s_x[0]  = 64'd50;
    s_d[0]  = 32'd5;
    tick();
    chk("credit_returned", bus.req_ready[0], 1'b1);
    s_valid = 2'b00;
    repeat (5) tick();

    // Reset mid-flight: two ops issued, then async reset
    s_valid = 2'b11;
    s_x[0]  = 64'd1000;
    s_d[0]  = 32'd10;
    s_x[1]  = 64'd77;
    s_d[1]  = 32'd8;
    tick();
    tick();
    s_rstn = 1'b0;
    repeat (2) tick();
    s_rstn  = 1'b1;
    s_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale_rsp", bus.rsp_valid, 2'b00);
    end

    // Contention: grants alternate starting with requester 0
    s_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      rand_op(0);
      rand_op(1);
      tick();
      chk("alternate", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    s_valid = 2'b00;
    repeat (6) tick();

    // Backpressure on requester 0
    s_valid = 2'b11;
    s_rr    = 2'b10;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      rand_op(0);
      rand_op(1);
      tick();
      if (bus.req_valid[0] && bus.req_ready[0]) n0++;
      if (bus.req_valid[1] && bus.req_ready[1]) n1++;
    end
    chk("bp_accepts0", 64'(n0), 64'(DEPTH));
    chk("bp_req1_moves", n1 >= 6, 1'b1);
    chk("bp_ready0_low", bus.req_ready[0], 1'b0);
    s_rr = 2'b11;
    tick();
    chk("bp_pop_cycle", bus.req_ready[0], 1'b0);
    tick();
    chk("bp_restored", bus.req_ready[0], 1'b1);

    // Random traffic
    for (int k = 0; k < 10000; k++) begin
      s_valid = 2'($urandom_range(0, 3));
      s_rr    = 2'($urandom_range(0, 3));
      rand_op(0);
      rand_op(1);
      tick();
    end

    // Drain: every accepted op must have come back exactly once
    s_valid = 2'b00;
    s_rr    = 2'b11;
    repeat (10) tick();
    chk("drain0", 64'(fq[0].size()), 64'd0);
    chk("drain1", 64'(fq[1].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
